cpu_error_ctrl: RTL and testbench
=================================

// Module: cpu_error_ctrl
// PURPOSE
//  Error-path controller for the 7-stage pipeline. Priority-encodes the per-stage and cache error strobes,
//  latches the first error and its source, and drives a halt request to the pipeline through a
//  DRAIN -> HALTED handshake with timeout. Logs every error event (source, timestamp) in a small FIFO
//  that the debug side reads out. The sticky error flag it produces is the CPU-level cpu_inner_error_o.
// PARAMETERS
//  NUM_SRC        10   number of error sources; src 0=icache,1=dcache,2=if,3=ift,4=id,5=launch,6=ex,7=mm,8=mem,9=wb
//  LOG_DEPTH      4    event FIFO entries, power of 2
//  TS_W           16   timestamp / cycle counter width
//  DRAIN_TIMEOUT  64   max cycles in DRAIN waiting for halt_ack_i, >=2
// PORTS
//  clk                clk input   1        system clock
//  rst_n              input   1            synchronous, active-low reset
//  err_src_i          input   NUM_SRC      per-source error strobes, level sampled each cycle
//  halt_ack_i         input   1            pipeline reports fully stopped
//  clr_i              input   1            debug clear, 1-cycle pulse
//  log_rd_i           input   1            pop log head, honoured only when log_valid_o=1
//  cpu_inner_error_o  output  1            sticky CPU error flag
//  halt_req_o         output  1            request pipeline stop
//  first_valid_o      output  1            first_src_o is valid
//  first_src_o        output  SRC_W        source id of first error, SRC_W=$clog2(NUM_SRC)
//  timeout_o          output  1            DRAIN exited by timeout, not by ack
//  log_valid_o        output  1            FIFO non-empty
//  log_src_o          output  SRC_W        head entry source id
//  log_multi_o        output  1            head entry had >1 source active
//  log_ts_o           output  TS_W         head entry timestamp
//  log_cnt_o          output  $clog2(LOG_DEPTH)+1  occupancy
//  log_ovf_o          output  1            sticky: an event was dropped, FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0. FSM=IDLE. FIFO empty. cycle counter=0.
//  - Cycle counter: free-running, +1 every cycle, wraps mod 2^TS_W.
//  - Event: any(err_src_i). src=highest set index (oldest stage wins). multi=popcount>1.
//    Entry {src,multi,ts=counter value in the same cycle}; one entry per erroring cycle.
//  - FIFO push on event. If full and no pop this cycle: drop, set log_ovf_o.
//    Full with simultaneous pop: push accepted, count unchanged. Pop on empty: ignored.
//    log_* outputs show head entry combinationally from storage (registered data, no extra latency).
//  - FSM IDLE: on event -> DRAIN. Latch first_src_o, first_valid_o=1, cpu_inner_error_o=1, halt_req_o=1.
//    All take effect the cycle after the strobe (1-cycle latency).
//  - FSM DRAIN: wait counter +1 each cycle.
//    halt_ack_i=1 -> HALTED.
//    Wait counter reaches DRAIN_TIMEOUT-1 without ack -> HALTED with timeout_o=1.
//    Ack and last timeout cycle together: ack wins, timeout_o=0.
//  - FSM HALTED: hold all flags. halt_req_o stays 1.
//  - clr_i: honoured only in HALTED. Next cycle: IDLE. Clears cpu_inner_error_o, halt_req_o,
//    first_valid_o, first_src_o, timeout_o, log_ovf_o. Flushes FIFO. Cycle counter is not cleared.
//    clr_i in IDLE/DRAIN: ignored, no side effects.
//  - Errors in DRAIN/HALTED: logged only. first_src_o unchanged.
//  - Event in same cycle as honoured clr_i: clr wins; event is neither logged nor latched.
//  - Reset mid-DRAIN/HALTED: everything returns to reset values on the next edge.
// STRUCTURE
//  - Shared package/header: source-id constants SRC_ICACHE..SRC_WB, FSM state encodings
//    ST_IDLE/ST_DRAIN/ST_HALTED, RstEnable.
//  - One sub-module err_event_fifo (sync FIFO: push/pop/flush, count, full/empty), parameterised
//    by depth and width. The priority encoder, FSM and counters stay in cpu_error_ctrl.
// TESTING
//  1. err_src_i=10'h040 one cycle at ts=5 -> next cycle error=1, halt_req=1, first_src=6;
//     log {6,0,5}, cnt=1.
//  2. err_src_i=10'h201 -> first_src=9, log_multi=1.
//     Later err_src_i=10'h004 in DRAIN -> second log entry src=2, first_src stays 9.
//  3. No ack, DRAIN_TIMEOUT=64 -> HALTED after 64 cycles, timeout_o=1.
//     Repeat with ack in the final cycle -> timeout_o=0.
//  4. Six error cycles, LOG_DEPTH=4, no reads -> cnt=4, log_ovf=1.
//     Then full + pop + event same cycle -> cnt stays 4.
//  5. clr_i in DRAIN -> ignored.
//     clr_i in HALTED together with an error strobe -> IDLE, all flags 0, cnt=0, event not logged.
//  6. rst_n=0 mid-DRAIN for one cycle -> all outputs 0, FSM IDLE, cycle counter 0.

Source files
------------

// File: rtl/cpu_error_ctrl_pkg.sv
// Shared definitions for the CPU error-path controller: source ids, FSM states, reset level.
package cpu_error_ctrl_pkg;

    localparam int unsigned SRC_ICACHE = 0;
    localparam int unsigned SRC_DCACHE = 1;
    localparam int unsigned SRC_IF     = 2;
    localparam int unsigned SRC_IFT    = 3;
    localparam int unsigned SRC_ID     = 4;
    localparam int unsigned SRC_LAUNCH = 5;
    localparam int unsigned SRC_EX     = 6;
    localparam int unsigned SRC_MM     = 7;
    localparam int unsigned SRC_MEM    = 8;
    localparam int unsigned SRC_WB     = 9;

    // Level of rst_n that resets the block (synchronous).
    localparam logic RstEnable = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage

// File: rtl/cpu_error_ctrl_if.sv
// Error-controller signal bundle: error strobes, halt handshake, debug clear and log readout.
interface cpu_error_ctrl_if #(
    parameter int unsigned NUM_SRC   = 10,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned TS_W      = 16
);
    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(LOG_DEPTH) + 1;

    logic [NUM_SRC-1:0] err_src_i;
    logic               halt_ack_i;
    logic               clr_i;
    logic               log_rd_i;
    logic               cpu_inner_error_o;
    logic               halt_req_o;
    logic               first_valid_o;
    logic [SRC_W-1:0]   first_src_o;
    logic               timeout_o;
    logic               log_valid_o;
    logic [SRC_W-1:0]   log_src_o;
    logic               log_multi_o;
    logic [TS_W-1:0]    log_ts_o;
    logic [CNT_W-1:0]   log_cnt_o;
    logic               log_ovf_o;

    modport slave (
        input  err_src_i, halt_ack_i, clr_i, log_rd_i,
        output cpu_inner_error_o, halt_req_o, first_valid_o, first_src_o, timeout_o,
               log_valid_o, log_src_o, log_multi_o, log_ts_o, log_cnt_o, log_ovf_o
    );

    modport master (
        output err_src_i, halt_ack_i, clr_i, log_rd_i,
        input  cpu_inner_error_o, halt_req_o, first_valid_o, first_src_o, timeout_o,
               log_valid_o, log_src_o, log_multi_o, log_ts_o, log_cnt_o, log_ovf_o
    );

endinterface

// File: rtl/err_event_fifo.sv
// Synchronous event FIFO with flush; head word is read straight from storage.
module err_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];
    assign cnt_o   = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/cpu_error_ctrl.sv
// Error-path controller: priority-encodes error strobes, latches the first error,
// runs the DRAIN -> HALTED halt handshake with timeout, and logs every error event.
module cpu_error_ctrl
    import cpu_error_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC       = 10,
    parameter int unsigned LOG_DEPTH     = 4,
    parameter int unsigned TS_W          = 16,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_error_ctrl_if.slave   bus
);
    localparam int unsigned SRC_W  = $clog2(NUM_SRC);
    localparam int unsigned CNT_W  = $clog2(LOG_DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(DRAIN_TIMEOUT);
    localparam int unsigned ENT_W  = SRC_W + 1 + TS_W;

    state_e             state_q;
    logic [TS_W-1:0]    ts_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               err_q;
    logic               halt_q;
    logic               first_valid_q;
    logic [SRC_W-1:0]   first_src_q;
    logic               timeout_q;
    logic               ovf_q;

    logic               evt;
    logic               evt_multi;
    logic [SRC_W-1:0]   evt_src;
    logic               clr_hon;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENT_W-1:0]   head;
    logic [CNT_W-1:0]   cnt;
    logic               full;
    logic               empty;

    // Highest set index wins: later pipeline stages hold the oldest instruction.
    always_comb begin
        evt_src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.err_src_i[i]) evt_src = SRC_W'(i);
        end
    end

    assign evt       = |bus.err_src_i;
    assign evt_multi = |(bus.err_src_i & (bus.err_src_i - NUM_SRC'(1)));
    assign clr_hon   = bus.clr_i && (state_q == ST_HALTED);
    assign push      = evt && !clr_hon;
    assign pop       = bus.log_rd_i && !empty;
    assign drop      = push && full && !pop;

    err_event_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clr_hon),
        .push_i  (push),
        .pop_i   (bus.log_rd_i),
        .wdata_i ({evt_src, evt_multi, ts_q}),
        .rdata_o (head),
        .cnt_o   (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            state_q       <= ST_IDLE;
            ts_q          <= '0;
            wait_q        <= '0;
            err_q         <= 1'b0;
            halt_q        <= 1'b0;
            first_valid_q <= 1'b0;
            first_src_q   <= '0;
            timeout_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (clr_hon) begin
                state_q       <= ST_IDLE;
                wait_q        <= '0;
                err_q         <= 1'b0;
                halt_q        <= 1'b0;
                first_valid_q <= 1'b0;
                first_src_q   <= '0;
                timeout_q     <= 1'b0;
                ovf_q         <= 1'b0;
            end else begin
                if (drop) ovf_q <= 1'b1;
                unique case (state_q)
                    ST_IDLE: begin
                        if (evt) begin
                            state_q       <= ST_DRAIN;
                            wait_q        <= '0;
                            err_q         <= 1'b1;
                            halt_q        <= 1'b1;
                            first_valid_q <= 1'b1;
                            first_src_q   <= evt_src;
                        end
                    end
                    ST_DRAIN: begin
                        // Ack is tested first so it wins over the final timeout cycle.
                        if (bus.halt_ack_i) begin
                            state_q <= ST_HALTED;
                        end else if (wait_q == WAIT_W'(DRAIN_TIMEOUT - 1)) begin
                            state_q   <= ST_HALTED;
                            timeout_q <= 1'b1;
                        end else begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end
                    end
                    ST_HALTED: state_q <= ST_HALTED;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cpu_inner_error_o = err_q;
    assign bus.halt_req_o        = halt_q;
    assign bus.first_valid_o     = first_valid_q;
    assign bus.first_src_o       = first_src_q;
    assign bus.timeout_o         = timeout_q;
    assign bus.log_ovf_o         = ovf_q;
    assign bus.log_cnt_o         = cnt;
    assign bus.log_valid_o       = !empty;
    assign bus.log_src_o         = empty ? '0 : head[TS_W+1 +: SRC_W];
    assign bus.log_multi_o       = empty ? 1'b0 : head[TS_W];
    assign bus.log_ts_o          = empty ? '0 : head[TS_W-1:0];

endmodule

// File: tb/tb_cpu_error_ctrl.sv
// Directed plus randomized bench for cpu_error_ctrl against a queue-based behavioural model.
module tb_cpu_error_ctrl;

    localparam int NSRC  = 10;
    localparam int DEPTH = 4;
    localparam int TSW   = 16;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cpu_error_ctrl_if #(.NUM_SRC(NSRC), .LOG_DEPTH(DEPTH), .TS_W(TSW)) bus ();

    cpu_error_ctrl #(
        .NUM_SRC       (NSRC),
        .LOG_DEPTH     (DEPTH),
        .TS_W          (TSW),
        .DRAIN_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int src;
        int multi;
        int ts;
    } ev_t;

    ev_t q[$];
    bit  m_drain, m_halt, m_err, m_fv, m_to, m_ovf;
    int  m_wait, m_first, m_ts;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drain = 0; m_halt = 0; m_err = 0; m_fv = 0; m_to = 0; m_ovf = 0;
        m_wait = 0; m_first = 0; m_ts = 0;
    endtask

    task automatic model_cycle(input logic [9:0] err, input bit ack, input bit clr, input bit rd);
        int  src;
        bit  ev;
        ev  = (err != 0);
        src = 0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (err[i] && src == 0 && i != 0) src = i;
        end
        if (m_halt && clr) begin
            q.delete();
            m_drain = 0; m_halt = 0; m_err = 0; m_fv = 0; m_to = 0; m_ovf = 0;
            m_first = 0; m_wait = 0;
        end else begin
            if (rd && q.size() > 0) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back('{src, ($countones(err) > 1) ? 1 : 0, m_ts});
                else m_ovf = 1;
            end
            if (!m_drain && !m_halt) begin
                if (ev) begin
                    m_drain = 1; m_wait = 0; m_err = 1; m_fv = 1; m_first = src;
                end
            end else if (m_drain) begin
                m_wait++;
                if (ack) begin
                    m_drain = 0; m_halt = 1;
                end else if (m_wait == TMO) begin
                    m_drain = 0; m_halt = 1; m_to = 1;
                end
            end
        end
        m_ts = (m_ts + 1) % (1 << TSW);
    endtask

    task automatic check_all();
        chk("cpu_inner_error", bus.cpu_inner_error_o, m_err);
        chk("halt_req", bus.halt_req_o, (m_drain || m_halt) ? 1 : 0);
        chk("first_valid", bus.first_valid_o, m_fv);
        chk("first_src", bus.first_src_o, m_first);
        chk("timeout", bus.timeout_o, m_to);
        chk("log_ovf", bus.log_ovf_o, m_ovf);
        chk("log_cnt", bus.log_cnt_o, q.size());
        chk("log_valid", bus.log_valid_o, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0) begin
            chk("log_src", bus.log_src_o, q[0].src);
            chk("log_multi", bus.log_multi_o, q[0].multi);
            chk("log_ts", bus.log_ts_o, q[0].ts);
        end else begin
            chk("log_src_empty", bus.log_src_o, 0);
            chk("log_ts_empty", bus.log_ts_o, 0);
        end
    endtask

    task automatic step(input logic [9:0] err, input bit ack = 0, input bit clr = 0,
                        input bit rd = 0, input bit rst = 0);
        rst_n          = !rst;
        bus.err_src_i  = err;
        bus.halt_ack_i = ack;
        bus.clr_i      = clr;
        bus.log_rd_i   = rd;
        @(posedge clk);
        if (rst) model_reset();
        else model_cycle(err, ack, clr, rd);
        #1;
        check_all();
    endtask

    initial begin
        logic [9:0] e;
        model_reset();
        bus.err_src_i = '0; bus.halt_ack_i = 0; bus.clr_i = 0; bus.log_rd_i = 0;
        repeat (3) step(10'h000, 0, 0, 0, 1);
        chk("rst_error", bus.cpu_inner_error_o, 0);

        // single error at ts=5
        repeat (5) step(10'h000);
        step(10'h040);
        chk("t1_first_src", bus.first_src_o, 6);
        chk("t1_halt_req", bus.halt_req_o, 1);
        chk("t1_log_ts", bus.log_ts_o, 5);
        chk("t1_log_cnt", bus.log_cnt_o, 1);
        step(10'h000, 0, 1);
        chk("t5_clr_in_drain", bus.cpu_inner_error_o, 1);
        step(10'h000);
        step(10'h000, 1);
        step(10'h000, 0, 0, 1);
        chk("t1_pop", bus.log_cnt_o, 0);
        step(10'h000, 0, 1);
        chk("t1_clr", bus.halt_req_o, 0);

        // multi-source error, second error while draining, then timeout
        step(10'h201);
        chk("t2_first_src", bus.first_src_o, 9);
        chk("t2_multi", bus.log_multi_o, 1);
        step(10'h004);
        chk("t2_cnt", bus.log_cnt_o, 2);
        step(10'h000, 0, 0, 1);
        chk("t2_second_src", bus.log_src_o, 2);
        chk("t2_first_keep", bus.first_src_o, 9);
        repeat (70) step(10'h000);
        chk("t3_timeout", bus.timeout_o, 1);
        step(10'h000, 0, 1);

        // ack arriving in the final timeout cycle
        step(10'h100);
        repeat (TMO - 1) step(10'h000);
        chk("t3_no_early_to", bus.timeout_o, 0);
        step(10'h000, 1);
        chk("t3_ack_wins", bus.timeout_o, 0);
        step(10'h000, 0, 1);
        chk("t3_halted_clr", bus.cpu_inner_error_o, 0);

        // overflow, then full + pop + event
        repeat (6) begin
            e = 10'($urandom_range(1, 1023));
            step(e);
        end
        chk("t4_cnt_full", bus.log_cnt_o, 4);
        chk("t4_ovf", bus.log_ovf_o, 1);
        step(10'h001, 0, 0, 1);
        chk("t4_cnt_pop_push", bus.log_cnt_o, 4);
        step(10'h000, 1);
        step(10'h3ff, 0, 1);
        chk("t5_clr_cnt", bus.log_cnt_o, 0);
        chk("t5_clr_err", bus.cpu_inner_error_o, 0);
        chk("t5_clr_ovf", bus.log_ovf_o, 0);

        // reset mid-DRAIN restarts the cycle counter
        step(10'h080);
        repeat (3) step(10'h000);
        step(10'h000, 0, 0, 0, 1);
        chk("t6_rst_halt", bus.halt_req_o, 0);
        chk("t6_rst_cnt", bus.log_cnt_o, 0);
        step(10'h002);
        chk("t6_ts_zero", bus.log_ts_o, 0);
        chk("t6_first_src", bus.first_src_o, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'h000;
            step(e, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 249) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
